// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM, pipeline-control and fetched-instruction signals of the fetch stage.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [DATA_WIDTH-1:0] i_rom_instr;
  logic                  i_stall;
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_addr;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_valid;
  modport master (
    output o_rom_addr, o_instr, o_pc, o_valid,
    input  i_rom_instr, i_stall, i_redirect, i_redirect_addr
  );
  modport slave (
    input  o_rom_addr, o_instr, o_pc, o_valid,
    output i_rom_instr, i_stall, i_redirect, i_redirect_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven ROM fetch stage with stall, redirect and BREAK halt.
// Defining INSTR_FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_fetch_if.master      bus
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, opc_q, opc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  brk;
  assign brk = bus.i_rom_instr[31:26] == 6'h00 && bus.i_rom_instr[5:0] == 6'h0D;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      opc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bus.i_redirect) begin
      state_d = RUN;
      pc_d    = bus.i_redirect_addr;
      valid_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (!bus.i_stall) begin
      // a BREAK is still delivered, but the PC parks on it
      instr_d = bus.i_rom_instr;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = brk ? pc_q : pc_q + ADDR_WIDTH'(1);
      state_d = brk ? HALT : RUN;
    end
  end
  assign bus.o_rom_addr = pc_q;
  assign bus.o_instr    = instr_q;
  assign bus.o_pc       = opc_q;
  assign bus.o_valid    = valid_q;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, scnt_q;
  logic        run_free;
  assign run_free = state_q == RUN && !bus.i_redirect;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + {31'd0, run_free && !bus.i_stall};
      scnt_q <= scnt_q + {31'd0, run_free && bus.i_stall};
    end
  end
  assign o_fetch_cnt = fcnt_q;
  assign o_stall_cnt = scnt_q;
`endif
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the word address width of the instruction ROM and of the PC.
REQ-002 Parameter DATA_WIDTH, default 32, sets the instruction width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: i_clk  input  1  rising-edge clock.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 o_rom_addr  output  ADDR_WIDTH  word address driven to the ROM i_addr.
REQ-006 i_rom_instr  input  DATA_WIDTH  combinational instruction returned from the ROM o_instr.
REQ-007 i_stall  input  1  downstream not ready; hold all outputs and the PC.
REQ-008 i_redirect  input  1  branch/jump taken; load i_redirect_addr into the PC.
REQ-009 i_redirect_addr  input  ADDR_WIDTH  redirect target word address.
REQ-010 o_instr  output  DATA_WIDTH  registered fetched instruction.
REQ-011 o_pc  output  ADDR_WIDTH  word address of o_instr.
REQ-012 o_valid  output  1  o_instr/o_pc hold a valid fetched instruction.

Function
REQ-013 The block SHALL hold a PC register, and o_rom_addr SHALL equal the PC combinationally.
REQ-014 The FSM SHALL have the states IDLE, RUN and HALT.
REQ-015 IDLE SHALL last exactly one cycle after reset release, with o_valid=0 and the PC unchanged, then go to RUN.
REQ-016 In RUN with i_stall=0 and i_redirect=0: o_instr<=i_rom_instr, o_pc<=PC, o_valid<=1, PC<=PC+1.
REQ-017 Latency: the instruction at address A SHALL appear on o_instr one cycle after o_rom_addr=A.
REQ-018 PC arithmetic is modulo 2^ADDR_WIDTH, so the PC at all-ones SHALL wrap to 0 with no flag.
REQ-019 In RUN with i_stall=1 and i_redirect=0, the PC, o_instr, o_pc, o_valid and the state SHALL be held.
REQ-020 i_redirect=1 in any state (with or without i_stall) SHALL set PC<=i_redirect_addr and o_valid<=0 and move to RUN; redirect has highest priority.
REQ-021 Halt condition: in RUN, not stalled, not redirected, with i_rom_instr[31:26]==6'h00 and i_rom_instr[5:0]==6'h0D (BREAK), the BREAK SHALL be captured with o_valid=1, the PC SHALL NOT increment, and the state SHALL move to HALT.
REQ-022 In HALT, o_valid SHALL be 0 from the next cycle and the PC SHALL be held; i_stall is ignored; only i_redirect or reset exits HALT.
REQ-023 o_instr and o_pc SHALL retain their last values whenever o_valid is 0.

Reset
REQ-024 Asserting i_rst_n low at any time, including mid-stall or in HALT, SHALL immediately set PC=0, o_instr=0, o_pc=0, o_valid=0 and state=IDLE.
REQ-025 After reset, the first fetch SHALL be address 0, and o_valid SHALL first rise on the second rising edge after reset release.

Configuration
REQ-026 With macro INSTR_FETCH_PERF_CNT_EN defined, the block SHALL add outputs o_fetch_cnt[31:0] and o_stall_cnt[31:0].
REQ-027 o_fetch_cnt SHALL increment on each REQ-016 or REQ-021 capture, o_stall_cnt SHALL increment on each RUN cycle with i_stall=1 and i_redirect=0, both SHALL reset to 0, and both SHALL wrap.
REQ-028 Without INSTR_FETCH_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Sequential fetch: ROM[k]=k+32'h100 for k=0..6, no stall -> o_valid rises 2 edges after reset release and o_pc/o_instr step 0/0x100 through 6/0x106 on consecutive cycles.
REQ-030 Stall: assert i_stall for 3 cycles while o_pc=2 -> o_pc=2, o_instr=0x102, o_valid=1 are held, then o_pc=3 appears on the first cycle after release; o_stall_cnt=3 when the macro is defined.
REQ-031 Redirect with stall: i_redirect=1, i_stall=1, i_redirect_addr=0x0040 -> o_valid=0 next cycle, o_rom_addr=0x0040, and o_pc=0x0040 valid one cycle later.
REQ-032 Wrap-around: redirect to 0xFFFF -> o_pc=0xFFFF, then o_pc=0x0000 on the next cycle.
REQ-033 Halt: ROM[3]=32'h0000000D -> o_pc=3 is valid for one cycle, then o_valid=0 and o_rom_addr stays 3 for 10 cycles; a redirect to 0 resumes fetching.
REQ-034 Reset mid-run: pull i_rst_n low asynchronously between clock edges while o_pc=5 -> all outputs are 0 immediately and the REQ-025 sequence repeats.
